// File: rtl/shift_sequencer_if.sv
// ============================================================================
// Module   : shift_sequencer_if
// Brief    : Request/result bundle between register read and the shift sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_sequencer_if;
    logic        flush;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  shift_type;
    logic [7:0]  shift_amt;
    logic [31:0] rm_data;
    logic        carry_in;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic        carry_out;
    logic        busy;

    modport master (
        output flush, op_valid, shift_type, shift_amt, rm_data, carry_in, result_ready,
        input  op_ready, result_valid, result, carry_out, busy
    );

    modport slave (
        input  flush, op_valid, shift_type, shift_amt, rm_data, carry_in, result_ready,
        output op_ready, result_valid, result, carry_out, busy
    );
endinterface

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module   : shift_sequencer
// Brief    : Multi-cycle ARM register-specified shifter, STEP bits per cycle.
//            Optional macro SHIFT_SEQ_FASTPATH_EN: single-cycle path for 0<n<=STEP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer #(
    parameter int STEP = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    shift_sequencer_if.slave    bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [1:0] c_LSL = 2'b00;
    localparam logic [1:0] c_LSR = 2'b01;
    localparam logic [1:0] c_ASR = 2'b10;

    localparam logic [5:0] c_STEP = 6'(STEP);

    logic [1:0]  r_state;
    logic [1:0]  r_type;
    logic [31:0] r_val;
    logic        r_carry;
    logic [5:0]  r_rem;

    logic [5:0]  w_n;
    logic        w_ror32;
    logic        w_fast;
    logic [5:0]  w_k;
    logic        w_accept;

    // Shift by k (1..32) in one go; bit 32 of the return value is the carry-out.
    function automatic logic [32:0] f_shift(input logic [1:0] typ,
                                            input logic [31:0] val,
                                            input logic [5:0] k);
        logic [63:0] w;
        logic [32:0] r;
        w = '0;
        case (typ)
            c_LSL: begin
                w = {32'b0, val} << k;
                r = {w[32], w[31:0]};
            end
            c_LSR: begin
                w = {val, 32'b0} >> k;
                r = {w[31], w[63:32]};
            end
            c_ASR: begin
                w = $unsigned($signed({val, 32'b0}) >>> k);
                r = {w[31], w[63:32]};
            end
            default: begin
                w = {val, val} >> k;
                r = {w[31], w[31:0]};
            end
        endcase
        return r;
    endfunction

    always_comb begin
        w_n     = 6'd0;
        w_ror32 = 1'b0;
        case (bus.shift_type)
            c_LSL, c_LSR: w_n = (bus.shift_amt > 8'd33) ? 6'd33 : bus.shift_amt[5:0];
            c_ASR:        w_n = (bus.shift_amt > 8'd32) ? 6'd32 : bus.shift_amt[5:0];
            default: begin
                w_n     = {1'b0, bus.shift_amt[4:0]};
                w_ror32 = (bus.shift_amt != 8'd0) && (bus.shift_amt[4:0] == 5'd0);
            end
        endcase
    end

`ifdef SHIFT_SEQ_FASTPATH_EN
    assign w_fast = (w_n <= c_STEP);
`else
    assign w_fast = 1'b0;
`endif

    assign w_k      = (r_rem > c_STEP) ? c_STEP : r_rem;
    assign w_accept = bus.op_valid & bus.op_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_type  <= 2'b00;
            r_val   <= 32'd0;
            r_carry <= 1'b0;
            r_rem   <= 6'd0;
        end else if (bus.flush) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_type <= bus.shift_type;
                        if (w_n == 6'd0) begin
                            // ROR by a non-zero multiple of 32 leaves the value but reports bit 31.
                            r_val   <= bus.rm_data;
                            r_carry <= w_ror32 ? bus.rm_data[31] : bus.carry_in;
                            r_rem   <= 6'd0;
                            r_state <= c_DONE;
                        end else if (w_fast) begin
                            {r_carry, r_val} <= f_shift(bus.shift_type, bus.rm_data, w_n);
                            r_rem   <= 6'd0;
                            r_state <= c_DONE;
                        end else begin
                            r_val   <= bus.rm_data;
                            r_carry <= bus.carry_in;
                            r_rem   <= w_n;
                            r_state <= c_SHIFT;
                        end
                    end
                end
                c_SHIFT: begin
                    {r_carry, r_val} <= f_shift(r_type, r_val, w_k);
                    r_rem <= r_rem - w_k;
                    if (r_rem == w_k) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (bus.result_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.op_ready     = (r_state == c_IDLE) & ~bus.flush & ~reset;
    assign bus.result_valid = (r_state == c_DONE);
    assign bus.result       = r_val;
    assign bus.carry_out    = r_carry;
    assign bus.busy         = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module   : tb_shift_sequencer
// Brief    : Directed scoreboard bench for shift_sequencer (STEP = 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

    localparam int c_STEP = 8;
`ifdef SHIFT_SEQ_FASTPATH_EN
    localparam bit c_FAST = 1'b1;
`else
    localparam bit c_FAST = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        c;
        int          lat;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t sb[$];

    shift_sequencer_if sif ();

    shift_sequencer #(.STEP(c_STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial reference: one position per iteration.
    function automatic exp_t model(input logic [1:0] t, input logic [7:0] a,
                                   input logic [31:0] rm, input logic ci);
        exp_t e;
        int   n;
        logic [31:0] r;
        logic c;
        case (t)
            2'b00, 2'b01: n = (a > 8'd33) ? 33 : int'(a);
            2'b10:        n = (a > 8'd32) ? 32 : int'(a);
            default:      n = int'(a[4:0]);
        endcase
        r = rm;
        c = ci;
        for (int i = 0; i < n; i++) begin
            case (t)
                2'b00:   begin c = r[31]; r = {r[30:0], 1'b0}; end
                2'b01:   begin c = r[0];  r = {1'b0, r[31:1]}; end
                2'b10:   begin c = r[0];  r = {r[31], r[31:1]}; end
                default: begin c = r[0];  r = {r[0], r[31:1]}; end
            endcase
        end
        if (t == 2'b11 && a != 8'd0 && a[4:0] == 5'd0) c = rm[31];
        e.res = r;
        e.c   = c;
        if (n == 0 || (c_FAST && n <= c_STEP)) e.lat = 1;
        else e.lat = (n + c_STEP - 1) / c_STEP + 1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic [7:0] a,
                         input logic [31:0] rm, input logic ci);
        sif.shift_type = t;
        sif.shift_amt  = a;
        sif.rm_data    = rm;
        sif.carry_in   = ci;
    endtask

    // Issue one op, measure latency, optionally stall the consumer, then consume.
    task automatic run_op(input string tag, input logic [1:0] t, input logic [7:0] a,
                          input logic [31:0] rm, input logic ci, input int hold);
        exp_t e;
        int   lat;
        sb.push_back(model(t, a, rm, ci));
        chk({tag, "_ready"}, 32'(sif.op_ready), 32'd1);
        drive(t, a, rm, ci);
        sif.op_valid = 1'b1;
        tick();
        sif.op_valid = 1'b0;
        lat = 1;
        while (!sif.result_valid && lat < 64) begin
            tick();
            lat++;
        end
        e = sb.pop_front();
        chk({tag, "_lat"},    32'(lat), 32'(e.lat));
        chk({tag, "_result"}, sif.result, e.res);
        chk({tag, "_carry"},  32'(sif.carry_out), 32'(e.c));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_result"}, sif.result, e.res);
            chk({tag, "_hold_carry"},  32'(sif.carry_out), 32'(e.c));
            chk({tag, "_hold_valid"},  32'(sif.result_valid), 32'd1);
            chk({tag, "_hold_ready"},  32'(sif.op_ready), 32'd0);
            chk({tag, "_hold_busy"},   32'(sif.busy), 32'd1);
        end
        sif.result_ready = 1'b1;
        tick();
        sif.result_ready = 1'b0;
        chk({tag, "_consumed_valid"}, 32'(sif.result_valid), 32'd0);
        chk({tag, "_consumed_busy"},  32'(sif.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw_valid;
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        sif.flush        = 1'b0;
        sif.op_valid     = 1'b0;
        sif.result_ready = 1'b0;
        drive(2'b00, 8'd0, 32'd0, 1'b0);

        // Reset state
        tick();
        tick();
        chk("rst_op_ready",  32'(sif.op_ready), 32'd0);
        chk("rst_valid",     32'(sif.result_valid), 32'd0);
        chk("rst_result",    sif.result, 32'd0);
        chk("rst_carry",     32'(sif.carry_out), 32'd0);
        chk("rst_busy",      32'(sif.busy), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_op_ready_after", 32'(sif.op_ready), 32'd1);

        // Reset in the middle of an LSL #20
        drive(2'b00, 8'd20, 32'hDEADBEEF, 1'b1);
        sif.op_valid = 1'b1;
        tick();
        sif.op_valid = 1'b0;
        tick();
        chk("midrst_busy_before", 32'(sif.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_op_ready_in_reset", 32'(sif.op_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_busy",     32'(sif.busy), 32'd0);
        chk("midrst_valid",    32'(sif.result_valid), 32'd0);
        chk("midrst_result",   sif.result, 32'd0);
        chk("midrst_carry",    32'(sif.carry_out), 32'd0);
        chk("midrst_op_ready", 32'(sif.op_ready), 32'd1);

        // Main function and boundaries
        run_op("lsl1",     2'b00, 8'd1,   32'h80000001, 1'b0, 0);
        run_op("lsl32",    2'b00, 8'd32,  32'h00000001, 1'b0, 0);
        run_op("lsl33",    2'b00, 8'd33,  32'hFFFFFFFF, 1'b1, 0);
        run_op("asr40",    2'b10, 8'd40,  32'h80000000, 1'b0, 0);
        run_op("asr20pos", 2'b10, 8'd20,  32'h7ABCDEF1, 1'b0, 0);
        run_op("lsr4",     2'b01, 8'd4,   32'hF0000000, 1'b1, 0);
        run_op("lsr33",    2'b01, 8'd200, 32'hFFFFFFFF, 1'b1, 0);
        run_op("lsr32",    2'b01, 8'd32,  32'h80000000, 1'b0, 0);
        run_op("ror4",     2'b11, 8'd4,   32'h0000000F, 1'b0, 0);
        run_op("ror36",    2'b11, 8'd36,  32'h12345678, 1'b0, 0);
        run_op("ror32",    2'b11, 8'd32,  32'h80000000, 1'b0, 0);
        run_op("ror17",    2'b11, 8'd17,  32'h0001FFFF, 1'b0, 0);
        for (int t = 0; t < 4; t++) begin
            run_op($sformatf("zero_t%0d", t), 2'(t), 8'd0, 32'h12345678, 1'b1, 0);
        end

        // Consumer stall in DONE
        run_op("hold", 2'b01, 8'd12, 32'hF0F0F0F0, 1'b0, 3);
        chk("hold_op_ready_after", 32'(sif.op_ready), 32'd1);

        // Flush while idle blocks accept
        drive(2'b00, 8'd1, 32'd1, 1'b0);
        sif.flush    = 1'b1;
        sif.op_valid = 1'b1;
        #1;
        chk("idleflush_op_ready", 32'(sif.op_ready), 32'd0);
        tick();
        sif.flush    = 1'b0;
        sif.op_valid = 1'b0;
        chk("idleflush_busy", 32'(sif.busy), 32'd0);

        // Flush in the second SHIFT cycle of LSR #24
        drive(2'b01, 8'd24, 32'hFFFF0000, 1'b0);
        sif.op_valid = 1'b1;
        tick();
        sif.op_valid = 1'b0;
        saw_valid = int'(sif.result_valid);
        tick();
        saw_valid += int'(sif.result_valid);
        chk("flush_busy_before", 32'(sif.busy), 32'd1);
        sif.flush = 1'b1;
        tick();
        sif.flush = 1'b0;
        chk("flush_busy_after", 32'(sif.busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            saw_valid += int'(sif.result_valid);
            tick();
        end
        chk("flush_never_valid", 32'(saw_valid), 32'd0);
        run_op("after_flush", 2'b00, 8'd1, 32'h00000001, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
